// File: rtl/buzz_sched.sv
// buzz_sched: arbitrates the single buzzer pin between alarm, hourly chime and key beep
module buzz_sched #(
  parameter int TICK_DIV      = 50000,
  parameter int DIV_HI        = 50000,
  parameter int DIV_LO        = 62500,
  parameter int KEY_MS        = 100,
  parameter int ALARM_HALF_MS = 500,
  parameter int ALARM_SEC     = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] sec_in,
  input  logic [6:0] min_in,
  input  logic [4:0] hour_in,
  input  logic       alarm_en,
  input  logic [4:0] alarm_hour,
  input  logic [6:0] alarm_min,
  input  logic       alarm_stop,
  input  logic       key_pulse,
  output logic       buzz,
  output logic [1:0] src,
  output logic       busy
);
  localparam int D1   = DIV_LO > DIV_HI ? DIV_LO : DIV_HI;
  localparam int DMAX = D1 > TICK_DIV ? D1 : TICK_DIV;
  localparam int MMAX = KEY_MS > ALARM_HALF_MS ? KEY_MS : ALARM_HALF_MS;
  localparam int DW   = $clog2(DMAX + 1);
  localparam int MW   = $clog2(MMAX + 1);
  localparam int SW   = $clog2(ALARM_SEC + 1);
  typedef enum logic [1:0] {IDLE = 2'd0, KEY = 2'd1, CHIME = 2'd2, ALARM = 2'd3} state_t;
  state_t state, nxt;
  logic [6:0]    sec_q;
  logic [DW-1:0] tick_cnt, tone_cnt, div;
  logic [MW-1:0] ms_cnt;
  logic [SW-1:0] sec_cnt;
  logic gate, tone, mask;
  logic chime_lo, chime_hit, chime_ok, sec_chg, trig, tick, half_end, key_end, alarm_done;
  logic chg, ms_restart, tone_end, tone_nxt, gate_nxt;
  // request decode, arbitration and next-cycle tone/gate values
  always_comb begin
    chime_lo   = min_in == 7'd0 && sec_in == 7'd0;
    chime_hit  = (min_in == 7'd59 && sec_in >= 7'd50 && sec_in <= 7'd58 && !sec_in[0]) || chime_lo;
    chime_ok   = chime_hit && !mask;
    sec_chg    = sec_in != sec_q;
    trig       = alarm_en && sec_in == 7'd0 && sec_q != 7'd0 && hour_in == alarm_hour && min_in == alarm_min;
    tick       = tick_cnt == DW'(TICK_DIV - 1);
    half_end   = state == ALARM && tick && ms_cnt == MW'(ALARM_HALF_MS - 1);
    key_end    = state == KEY && tick && ms_cnt == MW'(KEY_MS - 1);
    alarm_done = alarm_stop || !alarm_en || (sec_chg && sec_cnt >= SW'(ALARM_SEC - 1));
    nxt = state == ALARM ? (alarm_done ? (chime_ok ? CHIME : IDLE) : ALARM)
        : trig           ? (alarm_stop ? IDLE : ALARM)
        : chime_ok       ? CHIME
        : state == CHIME ? IDLE
        : key_pulse      ? KEY
        : key_end        ? IDLE
        : state;
    chg        = nxt != state;
    ms_restart = chg || (state == KEY && nxt == KEY && key_pulse);
    div        = (nxt == CHIME && chime_lo) ? DW'(DIV_LO) : DW'(DIV_HI);
    tone_end   = tone_cnt >= div - 1'b1;
    tone_nxt   = chg ? 1'b0 : tone_end ? ~tone : tone;
    gate_nxt   = chg ? 1'b1 : half_end ? ~gate : gate;
  end
  // state, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      src      <= 2'd0;
      busy     <= 1'b0;
      buzz     <= 1'b0;
      sec_q    <= 7'd0;
      tick_cnt <= '0;
      tone_cnt <= '0;
      ms_cnt   <= '0;
      sec_cnt  <= '0;
      gate     <= 1'b0;
      tone     <= 1'b0;
      mask     <= 1'b0;
    end else begin
      state    <= nxt;
      src      <= nxt;
      busy     <= nxt != IDLE;
      buzz     <= nxt != IDLE && gate_nxt && tone_nxt;
      sec_q    <= sec_in;
      mask     <= trig ? 1'b1 : chime_hit ? mask : 1'b0;
      tick_cnt <= (ms_restart || tick) ? '0 : tick_cnt + 1'b1;
      ms_cnt   <= (ms_restart || half_end) ? '0 : (tick && ms_cnt != MW'(MMAX)) ? ms_cnt + 1'b1 : ms_cnt;
      sec_cnt  <= chg ? '0 : (state == ALARM && sec_chg && sec_cnt != SW'(ALARM_SEC)) ? sec_cnt + 1'b1 : sec_cnt;
      tone_cnt <= (chg || tone_end) ? '0 : tone_cnt + 1'b1;
      tone     <= tone_nxt;
      gate     <= gate_nxt;
    end
  end
endmodule

// File: tb/tb_buzz_sched.sv
// tb_buzz_sched: directed checks of key beep, chime, alarm, preemption and reset
module tb_buzz_sched;
  logic clk = 0, rst_n = 1;
  logic [6:0] sec_in, min_in, alarm_min;
  logic [4:0] hour_in, alarm_hour;
  logic alarm_en, alarm_stop, key_pulse;
  logic buzz, busy;
  logic [1:0] src;
  int nchk = 0, nerr = 0;

  buzz_sched #(.TICK_DIV(10), .DIV_HI(4), .DIV_LO(6), .KEY_MS(3), .ALARM_HALF_MS(2), .ALARM_SEC(60)) dut (
    .clk(clk), .rst_n(rst_n), .sec_in(sec_in), .min_in(min_in), .hour_in(hour_in),
    .alarm_en(alarm_en), .alarm_hour(alarm_hour), .alarm_min(alarm_min),
    .alarm_stop(alarm_stop), .key_pulse(key_pulse), .buzz(buzz), .src(src), .busy(busy));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_time(input int h, input int m, input int s);
    hour_in = 5'(h); min_in = 7'(m); sec_in = 7'(s);
  endtask

  initial begin
    set_time(1, 10, 5);
    alarm_en = 0; alarm_hour = 5'd7; alarm_min = 7'd30; alarm_stop = 0; key_pulse = 0;
    #2 rst_n = 0;
    #1;
    chk("rst_buzz", buzz, 0); chk("rst_src", src, 0); chk("rst_busy", busy, 0);
    @(posedge clk); #1 rst_n = 1;
    step(2);
    chk("idle_src", src, 0);

    // key beep: 30 cycles, extended by a second pulse at cycle 20
    key_pulse = 1; step(1); key_pulse = 0;
    chk("key_src", src, 1); chk("key_busy", busy, 1); chk("key_buzz0", buzz, 0);
    step(3); chk("key_buzz3", buzz, 0);
    step(1); chk("key_buzz4", buzz, 1);
    step(4); chk("key_buzz8", buzz, 0);
    step(11); key_pulse = 1; step(1); key_pulse = 0;
    chk("key_ext_src", src, 1);
    step(10); chk("key_30", src, 1);
    step(19); chk("key_49", src, 1);
    step(1); chk("key_50_src", src, 0); chk("key_50_buzz", buzz, 0); chk("key_50_busy", busy, 0);

    // chime: HI at 59:50..58 even seconds, LO at 00:00
    for (int s = 49; s <= 59; s++) begin
      set_time(1, 59, s);
      step(1);
      chk($sformatf("chime_src_%0d", s), src, (s >= 50 && s % 2 == 0) ? 2 : 0);
      step(3); chk($sformatf("chime_b3_%0d", s), buzz, 0);
      step(1); chk($sformatf("chime_b4_%0d", s), buzz, (s >= 50 && s % 2 == 0) ? 1 : 0);
      step(2);
    end
    set_time(2, 0, 0); step(1);
    chk("chime_lo_src", src, 2);
    step(5); chk("chime_lo_b5", buzz, 0);
    step(1); chk("chime_lo_b6", buzz, 1);
    set_time(2, 0, 1); step(1);
    chk("chime_end", src, 0);

    // alarm at 07:30 with gated tone and auto-stop after 60 second changes
    alarm_en = 1; set_time(7, 29, 59); step(2);
    chk("al_pre", src, 0);
    set_time(7, 30, 0); step(1);
    chk("al_src", src, 3);
    step(4); chk("al_b4", buzz, 1);
    step(8); chk("al_b12", buzz, 1);
    step(16); chk("al_b28_off", buzz, 0);
    step(16); chk("al_b44_on", buzz, 1);
    for (int i = 1; i <= 59; i++) begin
      set_time(7, 30, i); step(1);
    end
    chk("al_59chg", src, 3);
    set_time(7, 31, 0); step(1);
    chk("al_auto_src", src, 0); chk("al_auto_buzz", buzz, 0);

    // alarm stopped at 2 s
    set_time(7, 29, 59); step(2);
    set_time(7, 30, 0); step(1);
    chk("al2_src", src, 3);
    set_time(7, 30, 1); step(1);
    set_time(7, 30, 2); step(3);
    alarm_stop = 1; step(1); alarm_stop = 0;
    chk("stop_src", src, 0); chk("stop_buzz", buzz, 0);

    // key preempted by chime, key pulses dropped in chime
    alarm_en = 0; set_time(7, 59, 40); step(2);
    key_pulse = 1; step(1); key_pulse = 0;
    chk("pre_key", src, 1);
    step(6); chk("pre_key_buzz", buzz, 1);
    set_time(7, 59, 50); step(1);
    chk("pre_chime", src, 2); chk("pre_tone_rst", buzz, 0);
    step(3); chk("pre_b3", buzz, 0);
    step(1); chk("pre_b4", buzz, 1);
    key_pulse = 1; step(1); key_pulse = 0;
    chk("pre_key_drop", src, 2);
    set_time(7, 59, 51); step(1);
    chk("pre_no_key", src, 0);
    set_time(7, 59, 52); key_pulse = 1; step(1); key_pulse = 0;
    chk("entry_key_src", src, 2);
    set_time(7, 59, 53); step(1);
    chk("entry_key_drop", src, 0);

    // collision: alarm at 08:00 beats the LO chime
    alarm_en = 1; alarm_hour = 5'd8; alarm_min = 7'd0;
    set_time(7, 59, 59); step(2);
    set_time(8, 0, 0); step(1);
    chk("col_src", src, 3);
    step(4); chk("col_hi_tone", buzz, 1);
    alarm_stop = 1; step(1); alarm_stop = 0;
    chk("col_stop", src, 0);
    step(2); chk("col_chime_sup", src, 0);
    set_time(8, 0, 1); step(1);
    set_time(7, 59, 59); step(2);
    set_time(8, 0, 0); alarm_stop = 1; step(1); alarm_stop = 0;
    chk("trig_stop", src, 0);
    step(1); chk("trig_stop_after", src, 0);
    set_time(8, 0, 1); step(1);

    // asynchronous reset mid-alarm
    alarm_hour = 5'd7; alarm_min = 7'd30;
    set_time(7, 29, 59); step(2);
    set_time(7, 30, 0); step(1);
    step(4); chk("rma_buzz", buzz, 1);
    #2 rst_n = 0;
    #1;
    chk("rma_buzz0", buzz, 0); chk("rma_src0", src, 0); chk("rma_busy0", busy, 0);
    @(posedge clk); #1 rst_n = 1;
    step(3); chk("rma_no_refire", src, 0);
    set_time(7, 30, 1); step(2); chk("rma_sec1", src, 0);
    set_time(7, 29, 59); step(2);
    set_time(7, 30, 0); step(1);
    chk("rma_refire", src, 3);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
